// File: rtl/timer_arbiter_pkg.sv
// Shared types and defaults for the round-robin timer arbiter.
package timer_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/timer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request bit after ptr, wrapping modulo N.
module rr_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid_c,
  output logic [IDW-1:0] winner_c
);

  always_comb begin
    int unsigned idx;
    idx      = 0;
    valid_c  = 1'b0;
    winner_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + 32'd1 + i) % N;
      if (!valid_c && req[idx[IDW-1:0]]) begin
        valid_c  = 1'b1;
        winner_c = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// One down-counting timer shared round-robin between N requesters, with done pulse and toggle.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned IDW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] delay,
  output logic [N-1:0]       done,
  output logic               busy,
  output logic [IDW-1:0]     grant_id,
  output logic [WIDTH-1:0]   count,
  output logic               toggle
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N-1:0]     done_q, done_d;
  logic             busy_q, busy_d;
  logic             toggle_q, toggle_d;

  logic             arb_valid_c;
  logic [IDW-1:0]   arb_id_c;
  logic [WIDTH-1:0] delay_sel_c;

  rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
    .req      (req),
    .ptr      (rr_ptr_q),
    .valid_c  (arb_valid_c),
    .winner_c (arb_id_c)
  );

  assign delay_sel_c = delay[32'(arb_id_c)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      grant_q  <= '0;
      rr_ptr_q <= IDW'(N - 1);
      done_q   <= '0;
      busy_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      toggle_q <= toggle_d;
    end
  end

  // Cancel (owner drops req) takes priority over expiry in RUN.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    done_d   = '0;
    busy_d   = busy_q;
    toggle_d = toggle_q;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        busy_d  = 1'b0;
        if (arb_valid_c) begin
          state_d  = ST_RUN;
          count_d  = delay_sel_c;
          grant_d  = arb_id_c;
          rr_ptr_d = arb_id_c;
          busy_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!req[grant_q]) begin
          state_d = ST_IDLE;
          count_d = '0;
          busy_d  = 1'b0;
        end else if (count_q == '0) begin
          state_d  = ST_DONE;
          done_d   = N'(1) << grant_q;
          toggle_d = ~toggle_q;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        count_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign done     = done_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign count    = count_q;
  assign toggle   = toggle_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: latency, round-robin order, cancel, reset and wide delays.
module tb_timer_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 33;
  localparam int unsigned IDW   = 2;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] delay;
  logic [N-1:0]       done;
  logic               busy;
  logic [IDW-1:0]     grant_id;
  logic [WIDTH-1:0]   count;
  logic               toggle;

  int checks = 0;
  int errors = 0;
  logic             exp_tog;
  logic [WIDTH-1:0] max_d;

  timer_arbiter #(.N(N), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .delay    (delay),
    .done     (done),
    .busy     (busy),
    .grant_id (grant_id),
    .count    (count),
    .toggle   (toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_delay(input int unsigned i, input logic [WIDTH-1:0] d);
    delay[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_toggle"}, 64'(toggle), 64'(exp_tog));
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    delay   = '0;
    exp_tog = 1'b0;
    max_d   = '1;

    // Reset values
    tick(); tick();
    chk_idle("rst");
    chk("rst_grant", 64'(grant_id), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single request, delay 5
    req = 4'b0001;
    set_delay(0, 33'd5);
    tick();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_grant", 64'(grant_id), 64'd0);
    chk("t1_count5", 64'(count), 64'd5);
    for (int c = 4; c >= 0; c--) begin
      tick();
      chk("t1_count", 64'(count), 64'(c));
      chk("t1_nodone", 64'(done), 64'd0);
    end
    tick();
    exp_tog = ~exp_tog;
    chk("t1_done", 64'(done), 64'b0001);
    chk("t1_toggle", 64'(toggle), 64'(exp_tog));
    chk("t1_busy_done", 64'(busy), 64'd1);
    req = '0;
    tick();
    chk_idle("t1_end");

    // Fresh reset so requester 0 leads the round-robin
    rst_n = 1'b0;
    #1;
    exp_tog = 1'b0;
    chk("t2_rst_toggle", 64'(toggle), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // All requesting, zero delays: order 0,1,2,3,0
    delay = '0;
    req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_busy", 64'(busy), 64'd1);
      chk("t2_grant", 64'(grant_id), 64'(k % 4));
      chk("t2_nodone", 64'(done), 64'd0);
      tick();
      exp_tog = ~exp_tog;
      chk("t2_done", 64'(done), 64'(4'b0001 << (k % 4)));
      chk("t2_toggle", 64'(toggle), 64'(exp_tog));
      tick();
      chk_idle("t2_idle");
    end
    req = '0;
    tick();

    // Park pointer at 1 via a short grant to requester 1
    req = 4'b0010;
    tick();
    chk("t3_pre_grant", 64'(grant_id), 64'd1);
    tick();
    exp_tog = ~exp_tog;
    chk("t3_pre_done", 64'(done), 64'b0010);
    req = '0;
    tick();

    // Owner 2 cancels at count 3, pending 1 granted next
    set_delay(2, 33'd5);
    set_delay(1, 33'd2);
    req = 4'b0110;
    tick();
    chk("t3_grant2", 64'(grant_id), 64'd2);
    chk("t3_count5", 64'(count), 64'd5);
    tick(); tick();
    chk("t3_count3", 64'(count), 64'd3);
    req = 4'b0010;
    tick();
    chk_idle("t3_cancel");
    tick();
    chk("t3_grant1", 64'(grant_id), 64'd1);
    chk("t3_busy1", 64'(busy), 64'd1);
    chk("t3_count2", 64'(count), 64'd2);
    tick(); tick(); tick();
    exp_tog = ~exp_tog;
    chk("t3_done1", 64'(done), 64'b0010);
    chk("t3_toggle", 64'(toggle), 64'(exp_tog));
    req = '0;
    tick();

    // Cancel in the same cycle as expiry: cancel wins
    set_delay(0, 33'd1);
    req = 4'b0001;
    tick();
    chk("t4_grant0", 64'(grant_id), 64'd0);
    chk("t4_count1", 64'(count), 64'd1);
    tick();
    chk("t4_count0", 64'(count), 64'd0);
    req = '0;
    tick();
    chk_idle("t4_cancel");
    tick();
    chk_idle("t4_after");

    // Asynchronous reset mid-run
    set_delay(0, 33'd10);
    req = 4'b0001;
    tick();
    chk("t5_count10", 64'(count), 64'd10);
    rst_n = 1'b0;
    #1;
    exp_tog = 1'b0;
    chk_idle("t5_rst");
    chk("t5_rst_grant", 64'(grant_id), 64'd0);
    req = '0;
    tick();
    rst_n = 1'b1;
    set_delay(0, 33'd3);
    set_delay(2, 33'd3);
    req = 4'b0101;
    tick();
    chk("t5_first_grant", 64'(grant_id), 64'd0);
    chk("t5_busy", 64'(busy), 64'd1);
    req = 4'b0100;
    tick();
    chk_idle("t5_cancel0");
    tick();
    chk("t5_grant2", 64'(grant_id), 64'd2);
    chk("t5_count3", 64'(count), 64'd3);
    req = '0;
    tick();
    chk_idle("t5_end");

    // Maximum delay: no wrap, later delay edits ignored
    set_delay(0, max_d);
    req = 4'b0001;
    tick();
    chk("t6_grant0", 64'(grant_id), 64'd0);
    chk("t6_count_max", 64'(count), 64'h1_FFFF_FFFF);
    set_delay(0, 33'd5);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("t6_count", 64'(count), 64'h1_FFFF_FFFF - 64'(i));
    end
    req = '0;
    tick();
    chk_idle("t6_cancel");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
Shares one down-counting timer between N requesters. Each requester asks for a delay of D clock cycles. Requests are granted round-robin. When a granted delay expires, the owner gets a one-cycle done pulse and a shared toggle output flips. The block sits between client FSMs and the free-running counter datapath, and replaces per-client counters.

Parameters:
N, 4, number of requesters (2..16)
WIDTH, 33, timer/delay width in bits
IDW, $clog2(N), width of grant_id

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N  level request per requester; held until done or dropped to cancel
delay  in  N*WIDTH  flattened delay values; requester i uses bits [i*WIDTH +: WIDTH]
done  out  N  one-cycle completion pulse to the owning requester
busy  out  1  timer owned (state RUN or DONE)
grant_id  out  IDW  index of current owner; valid only while busy
count  out  WIDTH  remaining count; 0 when idle
toggle  out  1  inverts on every completed (not cancelled) delay

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, done=0, busy=0, grant_id=0, count=0, toggle=0, rr_ptr=N-1, so requester 0 has first priority. Reset mid-RUN aborts silently; no done pulse is issued.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: if any req bit is high at a rising edge:
  - the winner is the first set bit searching from rr_ptr+1, wrapping modulo N;
  - that edge loads count=delay[winner], sets grant_id=winner and rr_ptr=winner, and moves to RUN.
  - If no req is high, stay in IDLE.
- RUN, priority order at each edge:
  - req[grant_id]==0: cancel. Go to IDLE, count=0, no done, toggle unchanged. Cancel beats expiry when both occur in the same cycle.
  - else count==0: go to DONE.
  - else count decrements by 1.
- DONE (exactly one cycle): done[grant_id]=1, and toggle inverts on entry to DONE. The next edge returns to IDLE, with done=0 and count=0.
- Latency: with req sampled at edge E0, done is high in the cycle after edge E0+D+1. For D=0, that is the cycle after E0+1.
- Delay is sampled only at acceptance. Later changes to delay[i] are ignored.
- Other requesters' req bits are ignored while busy; they stay pending.
- The requester drops req in the cycle it sees done. If req is still high in IDLE, it is treated as a new request, arbitrated normally; round-robin then prefers the others.
- Arithmetic: count is unsigned WIDTH bits and never decrements below 0. D=2^WIDTH-1 is legal and must not wrap.
- done is one-hot or all-zero at all times.

Decomposition:
- Package timer_arbiter_pkg: state enum (IDLE, RUN, DONE), default WIDTH constant.
- One sub-module, rr_arbiter (N): inputs req and ptr; outputs a valid flag and winner index. Purely combinational priority rotate.
- The FSM, counter and toggle live in timer_arbiter.

Test Plan:
- Reset, then req=0001 with delay0=5 held -> busy rises 1 cycle later, count reads 5,4,3,2,1,0, done[0] pulses once 7 cycles after the req edge, toggle 0->1.
- req=1111 held with all delays 0 -> grants in order 0,1,2,3,0, one done per grant every 3 cycles, toggle flips each completion.
- Owner 2 drops req while count=3 -> returns to IDLE next cycle, no done, toggle unchanged; pending req[1] is granted the cycle after.
- Owner drops req in the same cycle count==0 -> no done, toggle unchanged (cancel wins).
- rst_n asserted mid-RUN with count=10 -> all outputs zero immediately; after release, req=0100 and req=0001 together -> requester 0 is granted first.
- delay0=2^33-1, run 20 cycles, then cancel -> count decrements monotonically from 0x1_FFFF_FFFF with no wrap; changing delay0 mid-run has no effect on count.
